// File: rtl/pio_button_array_if.sv
// CPU-side bus of the push-button port: Avalon-MM slave signals plus the interrupt line.
interface pio_button_array_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (output address, chipselect, write_n, writedata, input readdata, irq);
   modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pio_button_array.sv
// Multi-channel push-button port: synchroniser, debounce and edge capture per channel,
// masked level IRQ. Define PIO_INVERT_EN to add the per-channel INVERT register at address 6.
module pio_button_array #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   pio_button_array_if.slave    bus,
   input  logic [WIDTH-1:0]     in_port
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic             wr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] deb;
   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] upd, rise, fall, ev, clr;
   logic [WIDTH-1:0] irq_mask, edge_cap, rise_en, fall_en;
   logic [31:0]      rd_word;

   assign wr    = bus.chipselect & ~bus.write_n;
   assign wdata = bus.writedata[WIDTH-1:0];

   if (WIDTH < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^bus.writedata[31:WIDTH];
   end

`ifdef PIO_INVERT_EN
   logic [WIDTH-1:0] invert;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           invert <= '0;
      else if (wr && bus.address == 3'd6)  invert <= wdata;
   end

   assign sync_in = in_port ^ invert;
`else
   assign sync_in = in_port;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= sync_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= s[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Edges are taken from the debounce update itself so capture lands in the same cycle as DATA.
   always_comb begin
      upd = '0;
      for (int i = 0; i < WIDTH; i++) upd[i] = (s[i] != deb[i]) && (cnt[i] == CNT_LAST);
   end

   assign rise = upd & s;
   assign fall = upd & ~s;
   assign ev   = (rise & rise_en) | (fall & fall_en);
   assign clr  = (wr && bus.address == 3'd3) ? wdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask <= '0;
         edge_cap <= '0;
         rise_en  <= '1;
         fall_en  <= '0;
      end else begin
         if (wr && bus.address == 3'd2) irq_mask <= wdata;
         if (wr && bus.address == 3'd4) rise_en  <= wdata;
         if (wr && bus.address == 3'd5) fall_en  <= wdata;
         edge_cap <= (edge_cap & ~clr) | ev;
      end
   end

   always_comb begin
      rd_word = '0;
      case (bus.address)
         3'd0:    rd_word[WIDTH-1:0] = deb;
         3'd1:    rd_word[WIDTH-1:0] = s;
         3'd2:    rd_word[WIDTH-1:0] = irq_mask;
         3'd3:    rd_word[WIDTH-1:0] = edge_cap;
         3'd4:    rd_word[WIDTH-1:0] = rise_en;
         3'd5:    rd_word[WIDTH-1:0] = fall_en;
`ifdef PIO_INVERT_EN
         3'd6:    rd_word[WIDTH-1:0] = invert;
`endif
         default: rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) bus.readdata <= '0;
      else       bus.readdata <= rd_word;
   end

   assign bus.irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_pio_button_array.sv
// Directed bench for pio_button_array (WIDTH=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2).
module tb_pio_button_array;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_port;
   logic [31:0] rv;
   int n_vec = 0;
   int n_miscmp = 0;

   pio_button_array_if bus ();

   pio_button_array #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .in_port (in_port)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
      bus.address = a;
      @(negedge clk);
      d = bus.readdata;
   endtask

   initial begin
      reset          = 1'b1;
      in_port        = 4'h0;
      bus.address    = 3'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      repeat (2) @(negedge clk);
      check("reset_readdata", bus.readdata, 32'h0);
      check("reset_irq", {31'b0, bus.irq}, 32'h0);
      reset = 1'b0;
      rd_reg(3'd4, rv); check("reset_rise_en", rv, 32'hF);
      rd_reg(3'd5, rv); check("reset_fall_en", rv, 32'h0);
      rd_reg(3'd2, rv); check("reset_mask", rv, 32'h0);

      // press bit0: DATA moves on edge 10, visible in readdata after edge 11
      bus.address = 3'd0;
      in_port = 4'b0001;
      repeat (9) @(negedge clk);
      check("data_before_debounce", bus.readdata, 32'h0);
      repeat (3) @(negedge clk);
      check("data_after_debounce", bus.readdata, 32'h1);
      rd_reg(3'd1, rv); check("raw_level", rv, 32'h1);
      rd_reg(3'd3, rv); check("cap_rise_bit0", rv, 32'h1);
      check("irq_masked_off", {31'b0, bus.irq}, 32'h0);

      // 5-cycle glitch must be rejected
      wr_reg(3'd2, 32'h1);
      check("irq_mask_on", {31'b0, bus.irq}, 32'h1);
      in_port = 4'b0000;
      repeat (5) @(negedge clk);
      in_port = 4'b0001;
      repeat (20) @(negedge clk);
      rd_reg(3'd0, rv); check("glitch_data", rv, 32'h1);
      rd_reg(3'd3, rv); check("glitch_cap", rv, 32'h1);
      check("glitch_irq", {31'b0, bus.irq}, 32'h1);
      wr_reg(3'd3, 32'h1);
      check("clear_irq", {31'b0, bus.irq}, 32'h0);

      // falling-only capture on bit1
      wr_reg(3'd5, 32'h2);
      wr_reg(3'd4, 32'h0);
      wr_reg(3'd2, 32'h2);
      in_port = 4'b0011;
      repeat (20) @(negedge clk);
      rd_reg(3'd3, rv); check("press_no_cap", rv, 32'h0);
      rd_reg(3'd0, rv); check("press_data", rv, 32'h3);
      in_port = 4'b0001;
      repeat (9) @(negedge clk);
      check("fall_irq_early", {31'b0, bus.irq}, 32'h0);
      @(negedge clk);
      check("fall_irq_on_time", {31'b0, bus.irq}, 32'h1);
      repeat (10) @(negedge clk);
      rd_reg(3'd3, rv); check("fall_cap", rv, 32'h2);
      wr_reg(3'd3, 32'h2);
      check("fall_clear_irq", {31'b0, bus.irq}, 32'h0);
      rd_reg(3'd3, rv); check("fall_clear_cap", rv, 32'h0);

      // two captured channels, partial clear, set-beats-clear
      wr_reg(3'd4, 32'hF);
      wr_reg(3'd5, 32'h0);
      wr_reg(3'd2, 32'h0);
      in_port = 4'b0000;
      repeat (20) @(negedge clk);
      rd_reg(3'd3, rv); check("release_no_fall_en", rv, 32'h0);
      in_port = 4'b0101;
      repeat (20) @(negedge clk);
      rd_reg(3'd3, rv); check("cap_two", rv, 32'h5);
      wr_reg(3'd3, 32'h0);
      rd_reg(3'd3, rv); check("write0_no_effect", rv, 32'h5);
      wr_reg(3'd3, 32'h1);
      rd_reg(3'd3, rv); check("partial_clear", rv, 32'h4);
      wr_reg(3'd5, 32'h1);
      in_port = 4'b0100;
      repeat (9) @(negedge clk);
      wr_reg(3'd3, 32'h1);
      rd_reg(3'd3, rv); check("set_beats_clear", rv, 32'h5);

      // reset mid-count and with captured bits
      wr_reg(3'd2, 32'h5);
      check("irq_before_reset", {31'b0, bus.irq}, 32'h1);
      in_port = 4'b0110;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("async_reset_irq", {31'b0, bus.irq}, 32'h0);
      check("async_reset_readdata", bus.readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rd_reg(3'd4, rv); check("post_reset_rise_en", rv, 32'hF);
      rd_reg(3'd3, rv); check("post_reset_cap", rv, 32'h0);
      rd_reg(3'd0, rv); check("post_reset_data", rv, 32'h0);
      repeat (12) @(negedge clk);
      rd_reg(3'd3, rv); check("recapture_held", rv, 32'h6);
      rd_reg(3'd0, rv); check("recapture_data", rv, 32'h6);

`ifdef PIO_INVERT_EN
      reset = 1'b1;
      in_port = 4'hF;
      @(negedge clk);
      reset = 1'b0;
      wr_reg(3'd6, 32'hF);
      rd_reg(3'd6, rv); check("invert_reg", rv, 32'hF);
      repeat (20) @(negedge clk);
      rd_reg(3'd0, rv); check("invert_data_low", rv, 32'h0);
      rd_reg(3'd3, rv); check("invert_no_edge", rv, 32'h0);
      in_port = 4'hE;
      repeat (12) @(negedge clk);
      rd_reg(3'd0, rv); check("invert_data_bit0", rv, 32'h1);
      rd_reg(3'd3, rv); check("invert_rise_cap", rv, 32'h1);
`else
      wr_reg(3'd6, 32'hF);
      rd_reg(3'd6, rv); check("addr6_reads_zero", rv, 32'h0);
      rd_reg(3'd7, rv); check("addr7_reads_zero", rv, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end
endmodule
